// File: rtl/dpe_demultiplexer.sv
// dpe_demultiplexer: routes the DPE egress AXI-Stream to the CPU or one of four Ethernet outputs by tuser_dst
// Ports: clk, rst_n (async active-low), pause (stop at next packet boundary), is_idle,
//   drop_cnt[15:0] (saturating unknown-destination drops), from_dpe_* (AXI-Stream slave),
//   to_cpu_* / to_eth_1_* .. to_eth_4_* (AXI-Stream masters, one per destination).
// Widths and destination addresses are parameters whose defaults mirror dpe_pkg.
// Define DPE_DEMUX_SKID_EN to put a 2-entry registered skid buffer on every output.
module dpe_demultiplexer #(
  parameter int DATA_W = 32,
  parameter int KEEP_W = DATA_W / 8,
  parameter int STAGE_W = 4,
  parameter int ADDR_W = 3,
  parameter logic [ADDR_W-1:0] DPE_ADDR_CPU = ADDR_W'(0),
  parameter logic [ADDR_W-1:0] DPE_ADDR_ETH_1 = ADDR_W'(1),
  parameter logic [ADDR_W-1:0] DPE_ADDR_ETH_2 = ADDR_W'(2),
  parameter logic [ADDR_W-1:0] DPE_ADDR_ETH_3 = ADDR_W'(3),
  parameter logic [ADDR_W-1:0] DPE_ADDR_ETH_4 = ADDR_W'(4)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pause,
  output logic               is_idle,
  output logic [15:0]        drop_cnt,
  input  logic               from_dpe_tvalid,
  output logic               from_dpe_tready,
  input  logic [DATA_W-1:0]  from_dpe_tdata,
  input  logic               from_dpe_tlast,
  input  logic [KEEP_W-1:0]  from_dpe_tkeep,
  input  logic               from_dpe_tuser_bypass_all,
  input  logic [STAGE_W-1:0] from_dpe_tuser_bypass_stage,
  input  logic [ADDR_W-1:0]  from_dpe_tuser_src,
  input  logic [ADDR_W-1:0]  from_dpe_tuser_dst,
  output logic               to_cpu_tvalid,
  input  logic               to_cpu_tready,
  output logic [DATA_W-1:0]  to_cpu_tdata,
  output logic               to_cpu_tlast,
  output logic [KEEP_W-1:0]  to_cpu_tkeep,
  output logic               to_cpu_tuser_bypass_all,
  output logic [STAGE_W-1:0] to_cpu_tuser_bypass_stage,
  output logic [ADDR_W-1:0]  to_cpu_tuser_src,
  output logic [ADDR_W-1:0]  to_cpu_tuser_dst,
  output logic               to_eth_1_tvalid,
  input  logic               to_eth_1_tready,
  output logic [DATA_W-1:0]  to_eth_1_tdata,
  output logic               to_eth_1_tlast,
  output logic [KEEP_W-1:0]  to_eth_1_tkeep,
  output logic               to_eth_1_tuser_bypass_all,
  output logic [STAGE_W-1:0] to_eth_1_tuser_bypass_stage,
  output logic [ADDR_W-1:0]  to_eth_1_tuser_src,
  output logic [ADDR_W-1:0]  to_eth_1_tuser_dst,
  output logic               to_eth_2_tvalid,
  input  logic               to_eth_2_tready,
  output logic [DATA_W-1:0]  to_eth_2_tdata,
  output logic               to_eth_2_tlast,
  output logic [KEEP_W-1:0]  to_eth_2_tkeep,
  output logic               to_eth_2_tuser_bypass_all,
  output logic [STAGE_W-1:0] to_eth_2_tuser_bypass_stage,
  output logic [ADDR_W-1:0]  to_eth_2_tuser_src,
  output logic [ADDR_W-1:0]  to_eth_2_tuser_dst,
  output logic               to_eth_3_tvalid,
  input  logic               to_eth_3_tready,
  output logic [DATA_W-1:0]  to_eth_3_tdata,
  output logic               to_eth_3_tlast,
  output logic [KEEP_W-1:0]  to_eth_3_tkeep,
  output logic               to_eth_3_tuser_bypass_all,
  output logic [STAGE_W-1:0] to_eth_3_tuser_bypass_stage,
  output logic [ADDR_W-1:0]  to_eth_3_tuser_src,
  output logic [ADDR_W-1:0]  to_eth_3_tuser_dst,
  output logic               to_eth_4_tvalid,
  input  logic               to_eth_4_tready,
  output logic [DATA_W-1:0]  to_eth_4_tdata,
  output logic               to_eth_4_tlast,
  output logic [KEEP_W-1:0]  to_eth_4_tkeep,
  output logic               to_eth_4_tuser_bypass_all,
  output logic [STAGE_W-1:0] to_eth_4_tuser_bypass_stage,
  output logic [ADDR_W-1:0]  to_eth_4_tuser_src,
  output logic [ADDR_W-1:0]  to_eth_4_tuser_dst
);
  localparam int PW = DATA_W + 1 + KEEP_W + 1 + STAGE_W + 2 * ADDR_W;
  typedef enum logic [1:0] {IDLE, HEAD, FWD, DROP} state_t;
  state_t r_state, w_next;
  logic [2:0] r_sel, w_dec, w_idx;
  logic [15:0] r_drop;
  logic w_known, w_route, w_tready, w_fire;
  logic [4:0] w_vld, w_rdy, w_ordy, w_ovld;
  logic [PW-1:0] w_beat;
  logic [PW-1:0] w_pay [5];
  logic [PW-1:0] w_opay [5];
  assign w_beat = {from_dpe_tdata, from_dpe_tlast, from_dpe_tkeep, from_dpe_tuser_bypass_all,
                   from_dpe_tuser_bypass_stage, from_dpe_tuser_src, from_dpe_tuser_dst};
  assign w_ordy = {to_eth_4_tready, to_eth_3_tready, to_eth_2_tready, to_eth_1_tready, to_cpu_tready};
  // Output index: 0 = CPU, 1..4 = ETH_1..ETH_4
  assign w_dec = (from_dpe_tuser_dst == DPE_ADDR_ETH_1) ? 3'd1 :
                 (from_dpe_tuser_dst == DPE_ADDR_ETH_2) ? 3'd2 :
                 (from_dpe_tuser_dst == DPE_ADDR_ETH_3) ? 3'd3 :
                 (from_dpe_tuser_dst == DPE_ADDR_ETH_4) ? 3'd4 : 3'd0;
  assign w_known = from_dpe_tuser_dst inside {DPE_ADDR_CPU, DPE_ADDR_ETH_1, DPE_ADDR_ETH_2,
                                              DPE_ADDR_ETH_3, DPE_ADDR_ETH_4};
  assign w_fire = from_dpe_tvalid && w_tready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = pause ? IDLE : HEAD;
      // A single-beat packet, routed or dropped, keeps us at the boundary
      HEAD: w_next = pause ? IDLE : !w_fire ? HEAD : from_dpe_tlast ? HEAD : w_known ? FWD : DROP;
      default: w_next = (w_fire && from_dpe_tlast) ? (pause ? IDLE : HEAD) : r_state;
    endcase
  end
  always_comb begin
    // The first beat routes straight from the decoder so no bubble is inserted
    w_idx = (r_state == HEAD) ? w_dec : r_sel;
    w_route = (r_state == HEAD && !pause && w_known) || r_state == FWD;
    w_tready = (r_state == DROP) ? 1'b1 : w_route ? w_rdy[w_idx] : (r_state == HEAD && !pause);
    for (int k = 0; k < 5; k++) begin
      w_vld[k] = w_route && from_dpe_tvalid && w_idx == 3'(k);
      w_pay[k] = w_vld[k] ? w_beat : '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sel <= 3'd0;
      r_drop <= '0;
    end else begin
      if (r_state == HEAD && w_fire && w_known) r_sel <= w_dec;
      if (r_state == HEAD && w_fire && !w_known && ~&r_drop) r_drop <= r_drop + 16'd1;
    end
  for (genvar i = 0; i < 5; i++) begin : g_out
`ifdef DPE_DEMUX_SKID_EN
    logic r_mv, r_sv;
    logic [PW-1:0] r_md, r_sd;
    // The skid entry only fills when the main entry is stalled, so ready is a pure flop output
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        r_mv <= 1'b0;
        r_sv <= 1'b0;
        r_md <= '0;
        r_sd <= '0;
      end else if (!r_mv || w_ordy[i]) begin
        r_mv <= r_sv | w_vld[i];
        r_md <= r_sv ? r_sd : w_pay[i];
        r_sv <= 1'b0;
      end else if (w_vld[i] && !r_sv) begin
        r_sv <= 1'b1;
        r_sd <= w_pay[i];
      end
    assign w_rdy[i] = !r_sv;
    assign w_ovld[i] = r_mv;
    assign w_opay[i] = r_mv ? r_md : '0;
`else
    assign w_rdy[i] = w_ordy[i];
    assign w_ovld[i] = w_vld[i];
    assign w_opay[i] = w_pay[i];
`endif
  end
  assign from_dpe_tready = w_tready;
  assign drop_cnt = r_drop;
  assign is_idle = r_state == IDLE && !(|w_ovld);
  assign {to_eth_4_tvalid, to_eth_3_tvalid, to_eth_2_tvalid, to_eth_1_tvalid, to_cpu_tvalid} = w_ovld;
  assign {to_cpu_tdata, to_cpu_tlast, to_cpu_tkeep, to_cpu_tuser_bypass_all,
          to_cpu_tuser_bypass_stage, to_cpu_tuser_src, to_cpu_tuser_dst} = w_opay[0];
  assign {to_eth_1_tdata, to_eth_1_tlast, to_eth_1_tkeep, to_eth_1_tuser_bypass_all,
          to_eth_1_tuser_bypass_stage, to_eth_1_tuser_src, to_eth_1_tuser_dst} = w_opay[1];
  assign {to_eth_2_tdata, to_eth_2_tlast, to_eth_2_tkeep, to_eth_2_tuser_bypass_all,
          to_eth_2_tuser_bypass_stage, to_eth_2_tuser_src, to_eth_2_tuser_dst} = w_opay[2];
  assign {to_eth_3_tdata, to_eth_3_tlast, to_eth_3_tkeep, to_eth_3_tuser_bypass_all,
          to_eth_3_tuser_bypass_stage, to_eth_3_tuser_src, to_eth_3_tuser_dst} = w_opay[3];
  assign {to_eth_4_tdata, to_eth_4_tlast, to_eth_4_tkeep, to_eth_4_tuser_bypass_all,
          to_eth_4_tuser_bypass_stage, to_eth_4_tuser_src, to_eth_4_tuser_dst} = w_opay[4];
endmodule

// File: tb/tb_dpe_demultiplexer.sv
// tb_dpe_demultiplexer: directed and randomized checks of dpe_demultiplexer against a packet-level model
module tb_dpe_demultiplexer;
  localparam int DW = 32, KW = 4, SW = 4, AW = 3;
  typedef struct packed {
    logic [DW-1:0] data;
    logic last;
    logic [KW-1:0] keep;
    logic ba;
    logic [SW-1:0] bs;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
  } beat_t;
  logic clk = 1'b0, rst_n = 1'b0, pause = 1'b1;
  logic is_idle;
  logic [15:0] drop_cnt;
  logic s_vld = 1'b0;
  logic s_rdy;
  beat_t s_b = '0;
  logic [4:0] o_vld, o_last, o_ba;
  logic [4:0] o_rdy = 5'h1f;
  logic [DW-1:0] o_data [5];
  logic [KW-1:0] o_keep [5];
  logic [SW-1:0] o_bs [5];
  logic [AW-1:0] o_src [5];
  logic [AW-1:0] o_dst [5];
  int checks = 0, errors = 0;
  beat_t exp_q [5][$];
  int exp_drop = 0;
  int recv [5] = '{default: 0};
  int base [5];
  int fire_cyc [5] = '{default: 0};
  int cyc = 0, rmode = 0;
  bit tog = 1'b0;
  dpe_demultiplexer dut (
    .clk(clk), .rst_n(rst_n), .pause(pause), .is_idle(is_idle), .drop_cnt(drop_cnt),
    .from_dpe_tvalid(s_vld), .from_dpe_tready(s_rdy), .from_dpe_tdata(s_b.data),
    .from_dpe_tlast(s_b.last), .from_dpe_tkeep(s_b.keep), .from_dpe_tuser_bypass_all(s_b.ba),
    .from_dpe_tuser_bypass_stage(s_b.bs), .from_dpe_tuser_src(s_b.src), .from_dpe_tuser_dst(s_b.dst),
    .to_cpu_tvalid(o_vld[0]), .to_cpu_tready(o_rdy[0]), .to_cpu_tdata(o_data[0]),
    .to_cpu_tlast(o_last[0]), .to_cpu_tkeep(o_keep[0]), .to_cpu_tuser_bypass_all(o_ba[0]),
    .to_cpu_tuser_bypass_stage(o_bs[0]), .to_cpu_tuser_src(o_src[0]), .to_cpu_tuser_dst(o_dst[0]),
    .to_eth_1_tvalid(o_vld[1]), .to_eth_1_tready(o_rdy[1]), .to_eth_1_tdata(o_data[1]),
    .to_eth_1_tlast(o_last[1]), .to_eth_1_tkeep(o_keep[1]), .to_eth_1_tuser_bypass_all(o_ba[1]),
    .to_eth_1_tuser_bypass_stage(o_bs[1]), .to_eth_1_tuser_src(o_src[1]), .to_eth_1_tuser_dst(o_dst[1]),
    .to_eth_2_tvalid(o_vld[2]), .to_eth_2_tready(o_rdy[2]), .to_eth_2_tdata(o_data[2]),
    .to_eth_2_tlast(o_last[2]), .to_eth_2_tkeep(o_keep[2]), .to_eth_2_tuser_bypass_all(o_ba[2]),
    .to_eth_2_tuser_bypass_stage(o_bs[2]), .to_eth_2_tuser_src(o_src[2]), .to_eth_2_tuser_dst(o_dst[2]),
    .to_eth_3_tvalid(o_vld[3]), .to_eth_3_tready(o_rdy[3]), .to_eth_3_tdata(o_data[3]),
    .to_eth_3_tlast(o_last[3]), .to_eth_3_tkeep(o_keep[3]), .to_eth_3_tuser_bypass_all(o_ba[3]),
    .to_eth_3_tuser_bypass_stage(o_bs[3]), .to_eth_3_tuser_src(o_src[3]), .to_eth_3_tuser_dst(o_dst[3]),
    .to_eth_4_tvalid(o_vld[4]), .to_eth_4_tready(o_rdy[4]), .to_eth_4_tdata(o_data[4]),
    .to_eth_4_tlast(o_last[4]), .to_eth_4_tkeep(o_keep[4]), .to_eth_4_tuser_bypass_all(o_ba[4]),
    .to_eth_4_tuser_bypass_stage(o_bs[4]), .to_eth_4_tuser_src(o_src[4]), .to_eth_4_tuser_dst(o_dst[4])
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  // Output monitor: every beat an output hands over must be the next one the model expects there
  beat_t pv [5];
  logic [4:0] p_stall = '0;
  always @(negedge clk) begin
    #2;
    if (!rst_n) p_stall = '0;
    else for (int i = 0; i < 5; i++) begin
      beat_t ob, eb;
      ob = {o_data[i], o_last[i], o_keep[i], o_ba[i], o_bs[i], o_src[i], o_dst[i]};
      if (p_stall[i]) begin
        checks++;
        assert (o_vld[i] === 1'b1 && ob === pv[i]) else begin
          errors++;
          $error("FAIL hold[%0d] got vld=%b %h need vld=1 %h", i, o_vld[i], ob, pv[i]);
        end
      end
      if (o_vld[i] !== 1'b1) begin
        checks++;
        assert (ob === '0) else begin
          errors++;
          $error("FAIL idle_payload[%0d] got %h need 0", i, ob);
        end
      end else if (o_rdy[i]) begin
        checks++;
        assert (exp_q[i].size() != 0) else begin
          errors++;
          $error("FAIL unexpected_beat[%0d] got %h need no beat", i, ob);
        end
        if (exp_q[i].size() != 0) begin
          eb = exp_q[i].pop_front();
          checks++;
          assert (ob === eb) else begin
            errors++;
            $error("FAIL beat[%0d] got %h need %h", i, ob, eb);
          end
          recv[i]++;
          fire_cyc[i] = cyc;
        end
      end
      p_stall[i] = o_vld[i] === 1'b1 && !o_rdy[i];
      pv[i] = ob;
    end
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h need %0h", tag, got, exp);
    end
  endtask
  function automatic int sat_add(input int a, input int n);
    return (a + n > 65535) ? 65535 : a + n;
  endfunction
  function automatic int pending();
    int s = 0;
    for (int i = 0; i < 5; i++) s += exp_q[i].size();
    return s;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
    tog = ~tog;
    o_rdy = (rmode == 0) ? 5'h1f : (rmode == 1) ? 5'($urandom) : {1'b1, tog, 3'b111};
  endtask
  // Sends the first nsend beats of an n-beat packet; beat 0 carries dst, later beats dst2
  task automatic send_pkt(input int n, input logic [AW-1:0] dst, input logic [AW-1:0] dst2,
                          input int pause_at, input int nsend);
    int w;
    for (int b = 0; b < nsend; b++) begin
      s_vld = 1'b1;
      s_b.data = $urandom;
      s_b.last = (b == n - 1);
      s_b.keep = 4'($urandom);
      s_b.ba = 1'($urandom);
      s_b.bs = 4'($urandom);
      s_b.src = 3'($urandom);
      s_b.dst = (b == 0) ? dst : dst2;
      if (b == pause_at) pause = 1'b1;
      w = 0;
      @(negedge clk);
      while (s_rdy !== 1'b1 && w < 200) begin
        tick();
        @(negedge clk);
        w++;
      end
      checks++;
      assert (w < 200) else begin
        errors++;
        $error("FAIL timeout beat %0d got tready=%b need 1", b, s_rdy);
      end
      if (w >= 200) break;
      if (dst <= 3'd4) exp_q[dst].push_back(s_b);
      else if (b == 0) exp_drop = sat_add(exp_drop, 1);
      tick();
    end
    s_vld = 1'b0;
  endtask
  task automatic drain();
    for (int k = 0; k < 100 && pending() != 0; k++) tick();
    chk("drain", 64'(pending()), 0);
  endtask
  initial begin
    int others, n;
    logic [AW-1:0] d;
    repeat (3) tick();
    chk("rst_tready", 64'(s_rdy), 0);
    chk("rst_tvalid", 64'(o_vld), 0);
    chk("rst_is_idle", 64'(is_idle), 1);
    chk("rst_drop_cnt", 64'(drop_cnt), 0);
    rst_n = 1'b1;
    tick();
    chk("paused_tready", 64'(s_rdy), 0);
    chk("paused_is_idle", 64'(is_idle), 1);
    pause = 1'b0;
    base = recv;
    send_pkt(3, 3'd2, 3'd2, -1, 3);
    drain();
    chk("eth2_beats", 64'(recv[2] - base[2]), 3);
    others = recv[0] + recv[1] + recv[3] + recv[4] - base[0] - base[1] - base[3] - base[4];
    chk("eth2_others", 64'(others), 0);
    chk("eth2_drop_cnt", 64'(drop_cnt), 0);
    send_pkt(1, 3'd0, 3'd0, -1, 1);
    send_pkt(1, 3'd1, 3'd1, -1, 1);
    send_pkt(1, 3'd4, 3'd4, -1, 1);
    drain();
    chk("b2b_cpu_eth1", 64'(fire_cyc[1] - fire_cyc[0]), 1);
    chk("b2b_eth1_eth4", 64'(fire_cyc[4] - fire_cyc[1]), 1);
    base = recv;
    rmode = 2;
    send_pkt(4, 3'd3, 3'd1, -1, 4);
    drain();
    rmode = 0;
    chk("sticky_eth3", 64'(recv[3] - base[3]), 4);
    chk("sticky_eth1", 64'(recv[1] - base[1]), 0);
    send_pkt(2, 3'd5, 3'd5, -1, 2);
    send_pkt(3, 3'd7, 3'd0, -1, 3);
    chk("drop_two", 64'(drop_cnt), 64'(exp_drop));
    chk("drop_two_abs", 64'(drop_cnt), 2);
    s_b = '{data: 32'h0, last: 1'b1, keep: 4'hf, ba: 1'b0, bs: 4'h0, src: 3'd0, dst: 3'd6};
    s_vld = 1'b1;
    repeat (65533) tick();
    s_vld = 1'b0;
    exp_drop = sat_add(exp_drop, 65533);
    chk("drop_full", 64'(drop_cnt), 64'(exp_drop));
    s_vld = 1'b1;
    tick();
    s_vld = 1'b0;
    exp_drop = sat_add(exp_drop, 1);
    chk("drop_saturate", 64'(drop_cnt), 16'hffff);
    base = recv;
    send_pkt(5, 3'd1, 3'd1, 1, 5);
    drain();
    chk("pause_beats", 64'(recv[1] - base[1]), 5);
    chk("pause_is_idle", 64'(is_idle), 1);
    s_b.dst = 3'd0;
    s_vld = 1'b1;
    repeat (3) tick();
    chk("pause_tready", 64'(s_rdy), 0);
    chk("pause_no_out", 64'(o_vld), 0);
    s_vld = 1'b0;
    pause = 1'b0;
    tick();
    chk("unpause_not_idle", 64'(is_idle), 0);
    send_pkt(6, 3'd0, 3'd0, -1, 3);
    s_vld = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tvalid", 64'(o_vld), 0);
    chk("midrst_tready", 64'(s_rdy), 0);
    chk("midrst_drop_cnt", 64'(drop_cnt), 0);
    chk("midrst_is_idle", 64'(is_idle), 1);
    s_vld = 1'b0;
    for (int i = 0; i < 5; i++) exp_q[i].delete();
    exp_drop = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("post_rst_tvalid", 64'(o_vld), 0);
    base = recv;
    send_pkt(2, 3'd4, 3'd4, -1, 2);
    drain();
    chk("post_rst_eth4", 64'(recv[4] - base[4]), 2);
    rmode = 1;
    for (int p = 0; p < 40; p++) begin
      d = 3'($urandom_range(0, 7));
      n = $urandom_range(1, 5);
      send_pkt(n, d, 3'($urandom_range(0, 7)), -1, n);
      repeat ($urandom_range(0, 2)) tick();
    end
    rmode = 0;
    drain();
    chk("rand_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dpe_demultiplexer.md
DPE_DEMULTIPLEXER -- requirements
Module: dpe_demultiplexer

Interface
REQ-001 SHALL have port clk, input, 1, single clock for all logic and all interfaces.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port pause, input, 1, request to stop accepting new packets at the next packet boundary.
REQ-004 SHALL have port is_idle, output, 1, high when paused, with no packet in flight and all outputs drained.
REQ-005 SHALL have port drop_cnt, output, 16, saturating count of packets dropped for an unknown destination.
REQ-006 SHALL have port from_dpe, dpe_if.s_axis, the single DPE egress stream.
REQ-007 SHALL have ports to_cpu, to_eth_1, to_eth_2, to_eth_3 and to_eth_4, each dpe_if.m_axis, one per destination.
REQ-008 SHALL take tdata, tkeep and tuser widths from dpe_pkg, and SHALL decode destinations against DPE_ADDR_CPU and DPE_ADDR_ETH_1..4.

Function
REQ-009 SHALL implement an FSM with states IDLE, HEAD, FWD and DROP.
REQ-010 IDLE: from_dpe.tready=0; SHALL go to HEAD when pause=0.
REQ-011 HEAD, pause=1: tready=0, no beat accepted, next state IDLE.
REQ-012 HEAD, pause=0, tvalid=1, known tuser_dst: route the beat combinationally to the decoded output (no bubble) and latch the selection in sel.
REQ-013 HEAD first-beat transfer, tlast=1: stay in HEAD; tlast=0: go to FWD.
REQ-014 HEAD, pause=0, tvalid=1, unknown tuser_dst: tready=1, beat discarded, drop_cnt incremented (saturate at 0xFFFF); tlast=1 stays in HEAD, tlast=0 goes to DROP.
REQ-015 FWD: route using latched sel and ignore tuser_dst on later beats; on a transfer with tlast=1, go to IDLE if pause=1, else HEAD.
REQ-016 DROP: tready=1 and beats discarded; on tvalid=1 with tlast=1, go to IDLE if pause=1, else HEAD.
REQ-017 Pause asserted mid-packet SHALL NOT truncate the packet; it takes effect only at tlast.
REQ-018 The selected output SHALL receive tvalid from from_dpe plus tdata, tlast, tkeep, tuser_bypass_all, tuser_bypass_stage, tuser_src and tuser_dst unchanged.
REQ-019 Every non-selected output SHALL drive tvalid=0 and all data/user fields '0.
REQ-020 from_dpe.tready SHALL equal the selected output's tready in HEAD/FWD and SHALL be 1 in DROP.
REQ-021 Back-pressure on one output SHALL NOT be propagated from the other outputs.
REQ-022 is_idle SHALL equal (state==IDLE) AND no output has tvalid=1.
REQ-023 Outputs SHALL obey AXI-Stream rules: once tvalid=1, tvalid and payload are held until tready=1.

Reset
REQ-024 On rst_n=0, the block SHALL asynchronously set state=IDLE, sel=CPU and drop_cnt=0.
REQ-025 During reset, all output tvalid and from_dpe.tready SHALL be 0, and is_idle SHALL be 1.
REQ-026 A reset mid-packet SHALL abandon the packet, with no remaining beats emitted after release.
REQ-027 After rst_n deasserts, the block SHALL leave IDLE on the first clk edge where pause=0.

Configuration
REQ-028 With DPE_DEMUX_SKID_EN defined, each output SHALL pass through a 2-entry registered skid buffer: 1-cycle latency, full throughput, tready registered toward the FSM, skid buffers cleared by rst_n.
REQ-029 With DPE_DEMUX_SKID_EN undefined, outputs SHALL be combinational from from_dpe with zero latency.
REQ-030 Function SHALL be identical in both builds apart from latency.

Verification
REQ-031 SHALL cover: pause=0, 3-beat packet with tuser_dst=DPE_ADDR_ETH_2 -> exactly 3 beats on to_eth_2, last with tlast=1; others tvalid=0; drop_cnt=0.
REQ-032 SHALL cover: back-to-back 1-beat packets to CPU, ETH_1, ETH_4 -> one beat on each output, in order, with no idle cycle between them (skid build: 1 cycle after input).
REQ-033 SHALL cover: 4-beat packet with dst changing on beat 2 and to_eth_3 tready toggled 1010 -> all 4 beats on the original output, payload held while stalled.
REQ-034 SHALL cover: two packets with an unknown dst -> consumed at tready=1, no output tvalid, drop_cnt=2; 0xFFFF plus one more drop -> stays 0xFFFF.
REQ-035 SHALL cover: pause raised on beat 2 of a 5-beat packet -> all 5 beats delivered, then state IDLE; is_idle=1 once outputs drain; tready=0 until pause=0.
REQ-036 SHALL cover: rst_n pulsed low on beat 3 of 6 -> outputs tvalid=0 immediately, drop_cnt=0, no stale beats after release.
